serial_magcom_ctrl: RTL and testbench

// - Sequencer that runs a single 1-bit magnitude comparator cell MSB-first over two

---
 rtl/serial_magcom_ctrl_pkg.sv | 5 +
 rtl/mag_bit_cmp.sv | 12 +
 rtl/serial_magcom_ctrl.sv | 87 ++++++++
 tb/tb_serial_magcom_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_magcom_ctrl_pkg.sv
// serial_magcom_ctrl_pkg: state encoding and default width for the serial magnitude comparator
package serial_magcom_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/mag_bit_cmp.sv
// mag_bit_cmp: combinational 1-bit magnitude comparator cell
module mag_bit_cmp (
    input  logic a,
    input  logic b,
    output logic l,
    output logic e,
    output logic g
);
    assign l = ~a & b;
    assign e = ~(a ^ b);
    assign g = a & ~b;
endmodule

// File: rtl/serial_magcom_ctrl.sv
// serial_magcom_ctrl: MSB-first sequencer driving one 1-bit comparator cell over WIDTH-bit operands
module serial_magcom_ctrl
    import serial_magcom_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    localparam int IW = $clog2(WIDTH);
    state_t           state;
    logic [IW-1:0]    index;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             dec, dlt, dgt;
    logic             cl, ce, cg;

    mag_bit_cmp u_cmp (.a(a_reg[index]), .b(b_reg[index]), .l(cl), .e(ce), .g(cg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            index <= IW'(WIDTH - 1);
            a_reg <= '0;
            b_reg <= '0;
            dec   <= 1'b0;
            dlt   <= 1'b0;
            dgt   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_reg <= op_a;
                    b_reg <= op_b;
                    index <= IW'(WIDTH - 1);
                    dec   <= 1'b0;
                    dlt   <= 1'b0;
                    dgt   <= 1'b0;
                    lt    <= 1'b0;
                    eq    <= 1'b0;
                    gt    <= 1'b0;
                    busy  <= 1'b1;
                    state <= SCAN;
                end
                SCAN: begin
                    if (EARLY_EXIT && !ce) begin
                        lt    <= cl;
                        gt    <= cg;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (index == '0) begin
                        // in constant-latency mode an earlier difference overrides the last bit
                        lt    <= dec ? dlt : cl;
                        gt    <= dec ? dgt : cg;
                        eq    <= dec ? 1'b0 : ce;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        index <= index - 1'b1;
                        if (!dec && !ce) begin
                            dec <= 1'b1;
                            dlt <= cl;
                            dgt <= cg;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_magcom_ctrl.sv
// tb_serial_magcom_ctrl: directed vector bench for early-exit and constant-latency comparators
module tb_serial_magcom_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start0 = 1'b0;
    logic [7:0] op_a = '0, op_b = '0;
    logic       busy1, done1, lt1, eq1, gt1;
    logic       busy0, done0, lt0, eq0, gt0;
    logic       sel = 1'b0;
    logic [4:0] o1, o0, o;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    serial_magcom_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a), .op_b(op_b),
        .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1));

    serial_magcom_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op_a(op_a), .op_b(op_b),
        .busy(busy0), .done(done0), .lt(lt0), .eq(eq0), .gt(gt0));

    // o = {busy, done, lt, eq, gt} of the selected instance
    assign o1 = {busy1, done1, lt1, eq1, gt1};
    assign o0 = {busy0, done0, lt0, eq0, gt0};
    assign o  = sel ? o0 : o1;

    typedef struct {
        bit         ee0;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] res;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int n);
        int k, bc;
        bit got;
        string nm;
        nm = $sformatf("v%0d", n);
        sel = v.ee0;
        @(negedge clk);
        op_a = v.a;
        op_b = v.b;
        if (v.ee0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        start1 = 1'b0;
        k = 0;
        bc = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o[3]) begin
                got = 1;
                break;
            end
            bc += int'(o[4]);
            k++;
        end
        chk({nm, "_done_seen"}, int'(got), 1);
        chk({nm, "_latency"}, k, v.lat);
        chk({nm, "_busy_cycles"}, bc, v.lat);
        chk({nm, "_result"}, int'(o[2:0]), int'(v.res));
        chk({nm, "_busy_at_done"}, int'(o[4]), 0);
        @(negedge clk);
        chk({nm, "_done_width"}, int'(o[3]), 0);
        repeat (2) @(negedge clk);
        chk({nm, "_hold"}, int'(o[2:0]), int'(v.res));
        chk({nm, "_idle_busy"}, int'(o[4]), 0);
    endtask

    vec_t vecs[$];

    initial begin
        int k;
        bit seen;
        // res = {lt, eq, gt}
        vecs.push_back('{1'b0, 8'h80, 8'h7F, 3'b001, 1});
        vecs.push_back('{1'b0, 8'h05, 8'h06, 3'b100, 7});
        vecs.push_back('{1'b0, 8'hA5, 8'hA5, 3'b010, 8});
        vecs.push_back('{1'b0, 8'h00, 8'h01, 3'b100, 8});
        vecs.push_back('{1'b0, 8'hFF, 8'h00, 3'b001, 1});
        vecs.push_back('{1'b0, 8'h10, 8'h01, 3'b001, 4});
        vecs.push_back('{1'b0, 8'h01, 8'h00, 3'b001, 8});
        vecs.push_back('{1'b1, 8'h80, 8'h7F, 3'b001, 8});
        vecs.push_back('{1'b1, 8'h05, 8'h06, 3'b100, 8});
        vecs.push_back('{1'b1, 8'h5A, 8'h5A, 3'b010, 8});
        vecs.push_back('{1'b1, 8'h01, 8'h00, 3'b001, 8});
        vecs.push_back('{1'b1, 8'h7F, 8'h80, 3'b100, 8});

        repeat (3) @(negedge clk);
        chk("reset_ee1", int'(o1), 0);
        chk("reset_ee0", int'(o0), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_ee1", int'(o1), 0);
        chk("idle_ee0", int'(o0), 0);

        for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

        // start raised mid-scan with a different operand must be ignored
        sel = 1'b0;
        @(negedge clk);
        op_a = 8'h10;
        op_b = 8'h01;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        k = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o[3]) begin
                seen = 1;
                break;
            end
            k++;
            if (k == 2) begin
                op_a = 8'h00;
                start1 = 1'b1;
            end
        end
        start1 = 1'b0;
        chk("midstart_done_seen", int'(seen), 1);
        chk("midstart_latency", k, 4);
        chk("midstart_result", int'(o[2:0]), 3'b001);
        @(negedge clk);
        chk("midstart_no_requeue", int'(o[4]), 0);
        repeat (2) @(negedge clk);
        chk("midstart_still_idle", int'(o[4:3]), 0);

        // async reset in the middle of a scan aborts without a done pulse
        @(negedge clk);
        op_a = 8'h10;
        op_b = 8'h01;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", int'(o1[4]), 1);
        rst_n = 1'b0;
        #1 chk("abort_outputs", int'(o1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o1[3]) seen = 1;
        end
        chk("abort_no_done", int'(seen), 0);
        chk("abort_idle", int'(o1), 0);
        run('{1'b0, 8'h33, 8'h34, 3'b100, 6}, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
